// File: rtl/ct_biu_io_sync_gen.sv
// ct_biu_io_sync_gen: interrupt/debug-request synchronisers and the single-outstanding CSR handshake to L2.
// Define CT_BIU_CSR_TIMEOUT_EN to add a WAIT timeout that completes with biu_csr_err=1 and zero read data.
module ct_biu_io_sync_gen #(
  parameter int INT_NUM  = 6,
  parameter int SYNC_STG = 2,
  parameter int CSR_WD   = 64,
  parameter int CSR_RD   = 128,
  parameter int TO_CYC   = 1023
) (
  input  logic                 coreclk,
  input  logic                 cpurst_b,
  input  logic [INT_NUM-1:0]   pad_biu_int,
  output logic [INT_NUM-1:0]   biu_cp0_int,
  output logic                 biu_xx_int_wakeup,
  input  logic                 pad_biu_dbgrq_b,
  output logic                 biu_had_sdb_req_b,
  output logic                 biu_xx_dbg_wakeup,
  input  logic                 biu_csr_sel,
  input  logic [15:0]          biu_csr_op,
  input  logic [CSR_WD-1:0]    biu_csr_wdata,
  output logic                 biu_pad_csr_sel,
  output logic [16+CSR_WD-1:0] biu_pad_csr_wdata,
  input  logic                 pad_biu_csr_cmplt,
  input  logic [CSR_RD-1:0]    pad_biu_csr_rdata,
  output logic                 biu_csr_cmplt,
  output logic [CSR_RD-1:0]    biu_csr_rdata,
  output logic                 biu_csr_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STG-1:0][INT_NUM-1:0] int_q;
  logic [SYNC_STG-1:0] dbg_q;
  logic sel_q, to_hit;
  logic [16+CSR_WD-1:0] wdata_q;
  logic [CSR_RD-1:0] rdata_q;

  if (SYNC_STG < 2 || SYNC_STG > 4 || TO_CYC < 1 || TO_CYC > 65535) begin : g_bad_param
    $error("ct_biu_io_sync_gen: SYNC_STG or TO_CYC out of range");
  end

  always_ff @(posedge coreclk or negedge cpurst_b)
    if (!cpurst_b) begin
      int_q <= '0;
      dbg_q <= '1;
    end else begin
      int_q <= {int_q[SYNC_STG-2:0], pad_biu_int};
      dbg_q <= {dbg_q[SYNC_STG-2:0], pad_biu_dbgrq_b};
    end

  assign biu_cp0_int       = int_q[SYNC_STG-1];
  assign biu_xx_int_wakeup = |biu_cp0_int;
  assign biu_had_sdb_req_b = dbg_q[SYNC_STG-1];
  assign biu_xx_dbg_wakeup = ~biu_had_sdb_req_b;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (biu_csr_sel && !sel_q) ? REQ : IDLE;
      REQ:     state_d = WAIT;
      WAIT:    state_d = (pad_biu_csr_cmplt || to_hit) ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge coreclk or negedge cpurst_b)
    if (!cpurst_b) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= biu_csr_sel;
    end

  // Data registers carry no reset; they only change on capture.
  always_ff @(posedge coreclk) begin
    if (state_q == IDLE && state_d == REQ) wdata_q <= {biu_csr_op, biu_csr_wdata};
    if (state_q == WAIT && state_d == DONE) rdata_q <= pad_biu_csr_cmplt ? pad_biu_csr_rdata : '0;
  end

  assign biu_pad_csr_sel   = state_q == REQ;
  assign biu_csr_cmplt     = state_q == DONE;
  assign biu_pad_csr_wdata = wdata_q;
  assign biu_csr_rdata     = rdata_q;

`ifdef CT_BIU_CSR_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic err_q;
  // Counter holds 0 outside WAIT, so it restarts at every WAIT entry.
  assign to_hit = state_q == WAIT && cnt_q == 16'(TO_CYC - 1);
  always_ff @(posedge coreclk or negedge cpurst_b)
    if (!cpurst_b) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == WAIT) ? cnt_q + 16'd1 : '0;
      err_q <= (state_q == WAIT && state_d == DONE) ? !pad_biu_csr_cmplt : err_q;
    end
  assign biu_csr_err = err_q;
`else
  assign to_hit      = 1'b0;
  assign biu_csr_err = 1'b0;
`endif
endmodule

// File: tb/tb_ct_biu_io_sync_gen.sv
// tb_ct_biu_io_sync_gen: scoreboard bench with random CSR traffic and random interrupt/debug inputs.
module tb_ct_biu_io_sync_gen;
  localparam int INT_NUM = 6, SYNC_STG = 3, CSR_WD = 64, CSR_RD = 128, TO_CYC = 8;
`ifdef CT_BIU_CSR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef struct {logic [16+CSR_WD-1:0] wd; int cyc;} req_t;
  typedef struct {logic [CSR_RD-1:0] rd; logic err; int cyc;} cmp_t;

  logic clk = 1'b0, cpurst_b = 1'b0;
  logic [INT_NUM-1:0] pad_biu_int = '0, biu_cp0_int;
  logic biu_xx_int_wakeup, biu_had_sdb_req_b, biu_xx_dbg_wakeup;
  logic pad_biu_dbgrq_b = 1'b1, biu_csr_sel = 1'b0, pad_biu_csr_cmplt = 1'b0;
  logic [15:0] biu_csr_op = '0;
  logic [CSR_WD-1:0] biu_csr_wdata = '0;
  logic biu_pad_csr_sel, biu_csr_cmplt, biu_csr_err;
  logic [16+CSR_WD-1:0] biu_pad_csr_wdata;
  logic [CSR_RD-1:0] pad_biu_csr_rdata = '0, biu_csr_rdata;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit rand_io = 0;
  req_t exp_req[$];
  cmp_t exp_cmp[$];
  logic [INT_NUM:0] hist[$];
  logic [16+CSR_WD-1:0] last_wd = '0;

  ct_biu_io_sync_gen #(.INT_NUM(INT_NUM), .SYNC_STG(SYNC_STG), .CSR_WD(CSR_WD),
                       .CSR_RD(CSR_RD), .TO_CYC(TO_CYC)) dut (
    .coreclk(clk), .cpurst_b(cpurst_b), .pad_biu_int(pad_biu_int), .biu_cp0_int(biu_cp0_int),
    .biu_xx_int_wakeup(biu_xx_int_wakeup), .pad_biu_dbgrq_b(pad_biu_dbgrq_b),
    .biu_had_sdb_req_b(biu_had_sdb_req_b), .biu_xx_dbg_wakeup(biu_xx_dbg_wakeup),
    .biu_csr_sel(biu_csr_sel), .biu_csr_op(biu_csr_op), .biu_csr_wdata(biu_csr_wdata),
    .biu_pad_csr_sel(biu_pad_csr_sel), .biu_pad_csr_wdata(biu_pad_csr_wdata),
    .pad_biu_csr_cmplt(pad_biu_csr_cmplt), .pad_biu_csr_rdata(pad_biu_csr_rdata),
    .biu_csr_cmplt(biu_csr_cmplt), .biu_csr_rdata(biu_csr_rdata), .biu_csr_err(biu_csr_err));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference history: what each edge sampled; a synchroniser output is the sample SYNC_STG-1 edges back.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!cpurst_b) hist.delete();
    else begin
      hist.push_back({pad_biu_dbgrq_b, pad_biu_int});
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [INT_NUM:0] e;
    req_t r;
    cmp_t c;
    e = (!cpurst_b || hist.size() < SYNC_STG) ? {1'b1, {INT_NUM{1'b0}}} : hist[hist.size()-SYNC_STG];
    chk("int_sync", 256'(biu_cp0_int), 256'(e[INT_NUM-1:0]));
    chk("int_wakeup", 256'(biu_xx_int_wakeup), 256'(|e[INT_NUM-1:0]));
    chk("dbg_sync", 256'(biu_had_sdb_req_b), 256'(e[INT_NUM]));
    chk("dbg_wakeup", 256'(biu_xx_dbg_wakeup), 256'(!e[INT_NUM]));
    if (!cpurst_b) begin
      chk("rst_pad_sel", 256'(biu_pad_csr_sel), 256'(0));
      chk("rst_cmplt", 256'(biu_csr_cmplt), 256'(0));
      chk("rst_err", 256'(biu_csr_err), 256'(0));
    end
    if (biu_pad_csr_sel) begin
      if (exp_req.size() == 0) chk("unexpected_pad_sel", 256'(biu_pad_csr_sel), 256'(0));
      else begin
        r = exp_req.pop_front();
        chk("req_cycle", 256'(cyc), 256'(r.cyc));
        chk("req_wdata", 256'(biu_pad_csr_wdata), 256'(r.wd));
        last_wd = r.wd;
      end
    end
    if (biu_csr_cmplt) begin
      if (exp_cmp.size() == 0) chk("unexpected_cmplt", 256'(biu_csr_cmplt), 256'(0));
      else begin
        c = exp_cmp.pop_front();
        chk("cmplt_cycle", 256'(cyc), 256'(c.cyc));
        chk("cmplt_rdata", 256'(biu_csr_rdata), 256'(c.rd));
        chk("cmplt_err", 256'(biu_csr_err), 256'(c.err));
        chk("wdata_held", 256'(biu_pad_csr_wdata), 256'(last_wd));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_io && $urandom_range(0, 1) == 0) pad_biu_int = INT_NUM'($urandom);
      if (rand_io && $urandom_range(0, 3) == 0) pad_biu_dbgrq_b = ~pad_biu_dbgrq_b;
    end
  endtask

  // L2 answers k edges after the request edge; a timeout wins only when k exceeds TO_CYC.
  task automatic csr_txn(int k, int hold, bit glitch, logic [15:0] op, logic [CSR_WD-1:0] wd,
                         logic [CSR_RD-1:0] rd);
    bit to;
    to = TO_EN && k > TO_CYC;
    exp_req.push_back('{wd: {op, wd}, cyc: cyc + 1});
    exp_cmp.push_back('{rd: to ? '0 : rd, err: to, cyc: cyc + 2 + (to ? TO_CYC : k)});
    biu_csr_op = op;
    biu_csr_wdata = wd;
    biu_csr_sel = 1'b1;
    if (glitch && k >= 3) begin
      tick(2);
      biu_csr_sel = 1'b0;
      tick(1);
      biu_csr_sel = 1'b1;
      tick(k - 2);
    end else tick(1 + k);
    biu_csr_op = 16'($urandom);
    biu_csr_wdata = {$urandom, $urandom};
    pad_biu_csr_cmplt = 1'b1;
    pad_biu_csr_rdata = rd;
    tick(1);
    pad_biu_csr_cmplt = 1'b0;
    pad_biu_csr_rdata = {4{$urandom}};
    tick(1 + hold);
    biu_csr_sel = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    cpurst_b = 1'b1;
    tick(4);
    pad_biu_int[2] = 1'b1;
    tick(2);
    chk("int2_before_3_edges", 256'(biu_cp0_int[2]), 256'(0));
    tick(1);
    chk("int2_after_3_edges", 256'(biu_cp0_int[2]), 256'(1));
    chk("wakeup_after_3_edges", 256'(biu_xx_int_wakeup), 256'(1));
    rand_io = 1;
    pad_biu_csr_cmplt = 1'b1;
    tick(1);
    pad_biu_csr_cmplt = 1'b0;
    tick(2);
    csr_txn(5, 0, 0, 16'h0012, 64'hA5A5, 128'h1234);
    csr_txn(3, 4, 0, 16'($urandom), {$urandom, $urandom}, {4{$urandom}});
`ifdef CT_BIU_CSR_TIMEOUT_EN
    csr_txn(TO_CYC + 3, 1, 0, 16'($urandom), {$urandom, $urandom}, {4{$urandom}});
    csr_txn(TO_CYC, 0, 0, 16'($urandom), {$urandom, $urandom}, {4{$urandom}});
`else
    csr_txn(TO_CYC + 10, 0, 0, 16'($urandom), {$urandom, $urandom}, {4{$urandom}});
`endif
    exp_req.push_back('{wd: {16'h00BE, 64'hDEAD}, cyc: cyc + 1});
    biu_csr_op = 16'h00BE;
    biu_csr_wdata = 64'hDEAD;
    biu_csr_sel = 1'b1;
    tick(4);
    cpurst_b = 1'b0;
    tick(2);
    biu_csr_sel = 1'b0;
    cpurst_b = 1'b1;
    tick(1);
    pad_biu_csr_cmplt = 1'b1;
    tick(1);
    pad_biu_csr_cmplt = 1'b0;
    tick(3);
    csr_txn(2, 0, 0, 16'($urandom), {$urandom, $urandom}, {4{$urandom}});
    for (int i = 0; i < 40; i++)
      csr_txn($urandom_range(1, TO_EN ? TO_CYC + 4 : 14), $urandom_range(0, 3), 1'($urandom),
              16'($urandom), {$urandom, $urandom}, {4{$urandom}});
    tick(5);
    chk("req_queue_drained", 256'(exp_req.size()), 256'(0));
    chk("cmplt_queue_drained", 256'(exp_cmp.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ct_biu_io_sync_gen.md
CT_BIU_IO_SYNC_GEN -- requirements
Module: ct_biu_io_sync_gen

Interface
REQ-001 The block SHALL have parameter INT_NUM, default 6, meaning the number of level interrupt channels synchronised.
REQ-002 The block SHALL have parameter SYNC_STG, default 2, meaning synchroniser flop depth, legal range 2..4.
REQ-003 The block SHALL have parameter CSR_WD, default 64, meaning CSR write-data width.
REQ-004 The block SHALL have parameter CSR_RD, default 128, meaning CSR read-data width.
REQ-005 The block SHALL have parameter TO_CYC, default 1023, meaning CSR timeout in coreclk cycles, legal range 1..65535.
REQ-006 The block SHALL have these ports, each as name direction width meaning:
- coreclk in 1 -- clock, all flops rising edge.
- cpurst_b in 1 -- reset, asynchronous, active-low.
- pad_biu_int in INT_NUM -- async level interrupts.
- biu_cp0_int out INT_NUM -- synchronised interrupts.
- biu_xx_int_wakeup out 1 -- OR of biu_cp0_int.
- pad_biu_dbgrq_b in 1 -- async debug request, active-low.
- biu_had_sdb_req_b out 1 -- synchronised debug request.
- biu_xx_dbg_wakeup out 1 -- inverse of biu_had_sdb_req_b.
- biu_csr_sel in 1 -- level CSR request, held until biu_csr_cmplt.
- biu_csr_op in 16 -- CSR opcode.
- biu_csr_wdata in CSR_WD -- CSR write data.
- biu_pad_csr_sel out 1 -- one-cycle request pulse to L2.
- biu_pad_csr_wdata out 16+CSR_WD -- {op, wdata}.
- pad_biu_csr_cmplt in 1 -- L2 completion pulse.
- pad_biu_csr_rdata in CSR_RD -- L2 read data.
- biu_csr_cmplt out 1 -- one-cycle completion pulse to core.
- biu_csr_rdata out CSR_RD -- captured read data.
- biu_csr_err out 1 -- timeout flag, valid with biu_csr_cmplt.

Function
REQ-007 Each pad_biu_int bit and pad_biu_dbgrq_b SHALL pass through a SYNC_STG-deep flop chain; the output equals the input sampled SYNC_STG edges earlier.
REQ-008 The CSR FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-009 IDLE->REQ SHALL occur on a rising edge of biu_csr_sel (sel high, registered sel low); biu_pad_csr_wdata SHALL be captured on that edge.
REQ-010 biu_pad_csr_sel SHALL be high exactly for the cycle in REQ; REQ->WAIT unconditionally.
REQ-011 WAIT->DONE SHALL occur on the edge sampling pad_biu_csr_cmplt=1; biu_csr_rdata SHALL be captured on that edge and biu_csr_err set to 0.
REQ-012 biu_csr_cmplt SHALL be high exactly for the cycle in DONE; DONE->IDLE unconditionally.
REQ-013 pad_biu_csr_cmplt SHALL be ignored outside WAIT; a sel rising edge outside IDLE SHALL be ignored.
REQ-014 biu_pad_csr_wdata and biu_csr_rdata SHALL hold their values until the next capture.

Reset
REQ-015 On cpurst_b low, the FSM SHALL go to IDLE from any state, including mid-transaction.
REQ-016 On cpurst_b low, all interrupt synchroniser flops and biu_cp0_int SHALL reset to 0.
REQ-017 On cpurst_b low, the debug synchroniser flops and biu_had_sdb_req_b SHALL reset to 1.
REQ-018 On cpurst_b low, biu_pad_csr_sel, biu_csr_cmplt, biu_csr_err, the registered sel and the timeout counter SHALL reset to 0; data registers are not reset.

Configuration
REQ-019 With CT_BIU_CSR_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle; when count reaches TO_CYC without completion, WAIT->DONE with biu_csr_err=1 and biu_csr_rdata=0.
REQ-020 With CT_BIU_CSR_TIMEOUT_EN defined, pad_biu_csr_cmplt on the timeout cycle SHALL take priority (err=0).
REQ-021 Without CT_BIU_CSR_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL persist until completion, and biu_csr_err SHALL be tied 0.

Verification
REQ-022 Reset: assert cpurst_b=0 -> biu_cp0_int=0, biu_had_sdb_req_b=1, biu_pad_csr_sel=0, biu_csr_cmplt=0.
REQ-023 Interrupt sync: SYNC_STG=3, pad_biu_int[2] 0->1 -> biu_cp0_int[2]=1 and biu_xx_int_wakeup=1 exactly 3 edges later.
REQ-024 CSR transaction: sel rises with op=16'h0012, wdata=64'hA5A5 -> one-cycle pad_sel with wdata={16'h0012,64'hA5A5}; cmplt after 5 cycles with rdata=128'h1234 -> one-cycle biu_csr_cmplt, rdata=128'h1234, err=0.
REQ-025 Stray and held inputs: cmplt pulse in IDLE -> no biu_csr_cmplt; sel held high across DONE -> no second request.
REQ-026 Timeout (macro on, TO_CYC=8): no cmplt -> biu_csr_cmplt with err=1, rdata=0 after 8 WAIT cycles; cmplt on the 8th cycle -> err=0.
REQ-027 Reset mid-WAIT: assert cpurst_b -> FSM IDLE; later cmplt ignored; next sel edge starts a fresh transaction.
